// File: rtl/wb_stage_mw_pkg.sv
// ============================================================================
// Module   : wb_stage_mw_pkg
// Brief    : Shared constants, types and helpers for the multi-lane writeback
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_stage_mw_pkg;

    localparam int MAX_LANES = 4;
    localparam int DBG_WEN_W = 4;
    localparam logic [MAX_LANES-1:0] MASK_ONE = MAX_LANES'(1);

    typedef logic [DBG_WEN_W-1:0] dbg_wen_t;

    // True when at most one bit of the mask is set.
    function automatic logic at_most_one(input logic [MAX_LANES-1:0] m);
        return (m & (m - MASK_ONE)) == '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_trace_ser.sv
// ============================================================================
// Module   : wb_trace_ser
// Brief    : Serialises a retired group onto the single-lane trace port
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_trace_ser
    import wb_stage_mw_pkg::*;
#(
    parameter int  LANES  = 2,
    parameter int  DATA_W = 32,
    parameter int  REG_AW = 5,
    parameter int  PC_W   = 32,
    localparam int TR_W   = 1 + REG_AW + DATA_W + PC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LANES-1:0]      load_mask,
    input  logic                  ws_valid,
    input  logic [LANES*TR_W-1:0] trace_bus,
    output logic                  ready_go,
    output dbg_wen_t              wen,
    output logic [PC_W-1:0]       pc,
    output logic [REG_AW-1:0]     wnum,
    output logic [DATA_W-1:0]     wdata
);

    logic [LANES-1:0]     pend_q, pend_d;
    logic [MAX_LANES-1:0] pend_ext;
    logic                 tracing;
    logic [TR_W-1:0]      sel;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [REG_AW-1:0]    wnum_q, wnum_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    always_comb begin
        pend_ext              = '0;
        pend_ext[LANES-1:0]   = pend_q;
        ready_go              = at_most_one(pend_ext);
        tracing               = ws_valid && (pend_q != '0);

        // Descending scan so the lowest pending lane is the one selected.
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel = trace_bus[i*TR_W +: TR_W];
            end
        end

        pend_d = pend_q;
        if (load) begin
            pend_d = load_mask;
        end else if (tracing) begin
            pend_d = pend_q & (pend_q - LANES'(1));
        end

        pc    = tracing ? sel[PC_W-1:0]                 : pc_q;
        wdata = tracing ? sel[PC_W +: DATA_W]           : wdata_q;
        wnum  = tracing ? sel[PC_W+DATA_W +: REG_AW]    : wnum_q;
        wen   = tracing ? {DBG_WEN_W{sel[TR_W-1]}}      : '0;

        pc_d    = pc;
        wdata_d = wdata;
        wnum_d  = wnum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= '0;
            pc_q    <= '0;
            wnum_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            pc_q    <= pc_d;
            wnum_q  <= wnum_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage_mw.sv
// ============================================================================
// Module   : wb_stage_mw
// Brief    : Multi-lane writeback stage: group RF write plus serial trace
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage_mw
    import wb_stage_mw_pkg::*;
#(
    parameter int  LANES  = 2,
    parameter int  DATA_W = 32,
    parameter int  REG_AW = 5,
    parameter int  PC_W   = 32,
    localparam int LANE_W = 2 + REG_AW + DATA_W + PC_W,
    localparam int RF_W   = 1 + REG_AW + DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ms_to_ws_valid,
    input  logic [LANES*LANE_W-1:0] ms_to_ws_bus,
    output logic                    ws_allowin,
    output logic [LANES*RF_W-1:0]   ws_to_rf_bus,
    output logic [PC_W-1:0]         debug_wb_pc,
    output dbg_wen_t                debug_wb_rf_wen,
    output logic [REG_AW-1:0]       debug_wb_rf_wnum,
    output logic [DATA_W-1:0]       debug_wb_rf_wdata
);

    localparam int TR_W = LANE_W - 1;

    logic                    ws_valid_q, ws_valid_d;
    logic                    rf_fire_q, rf_fire_d;
    logic [LANES*LANE_W-1:0] bus_q, bus_d;
    logic                    accept;
    logic                    ready_go;
    logic [LANES-1:0]        lane_v, gr_we, kill, we;
    logic [REG_AW-1:0]       dest   [LANES];
    logic [DATA_W-1:0]       result [LANES];
    logic [LANES*TR_W-1:0]   trace_bus;

    assign ws_allowin = !ws_valid_q || ready_go;

    always_comb begin
        accept = ms_to_ws_valid && ws_allowin;

        ws_valid_d = ws_valid_q;
        if (accept) begin
            ws_valid_d = 1'b1;
        end else if (ws_allowin) begin
            ws_valid_d = 1'b0;
        end

        // One-shot so a draining group writes the register file only once.
        rf_fire_d = rf_fire_q;
        if (accept) begin
            rf_fire_d = 1'b1;
        end else if (ws_valid_q) begin
            rf_fire_d = 1'b0;
        end

        bus_d = accept ? ms_to_ws_bus : bus_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            rf_fire_q  <= 1'b0;
            bus_q      <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            rf_fire_q  <= rf_fire_d;
            bus_q      <= bus_d;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_v[i] = bus_q[i*LANE_W + LANE_W - 1];
            gr_we[i]  = bus_q[i*LANE_W + LANE_W - 2];
            dest[i]   = bus_q[i*LANE_W + PC_W + DATA_W +: REG_AW];
            result[i] = bus_q[i*LANE_W + PC_W +: DATA_W];
            trace_bus[i*TR_W +: TR_W] = bus_q[i*LANE_W +: TR_W];
        end
    end

    // A later lane writing the same register overrides every earlier one.
    always_comb begin
        kill         = '0;
        we           = '0;
        ws_to_rf_bus = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_v[j] && gr_we[j] && (dest[j] == dest[i])) begin
                    kill[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            we[i] = ws_valid_q && rf_fire_q && lane_v[i] && gr_we[i] && !kill[i];
            ws_to_rf_bus[i*RF_W +: RF_W] = {we[i], dest[i], result[i]};
        end
    end

    wb_trace_ser #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .PC_W   (PC_W)
    ) u_trace_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_mask (ms_to_ws_bus_lane_v(ms_to_ws_bus)),
        .ws_valid  (ws_valid_q),
        .trace_bus (trace_bus),
        .ready_go  (ready_go),
        .wen       (debug_wb_rf_wen),
        .pc        (debug_wb_pc),
        .wnum      (debug_wb_rf_wnum),
        .wdata     (debug_wb_rf_wdata)
    );

    function automatic logic [LANES-1:0] ms_to_ws_bus_lane_v(input logic [LANES*LANE_W-1:0] b);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = b[i*LANE_W + LANE_W - 1];
        end
        return m;
    endfunction

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_mw.sv
// ============================================================================
// Module   : tb_wb_stage_mw
// Brief    : Directed self-checking bench for wb_stage_mw (2- and 4-lane)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage_mw;

    logic         clk;
    logic         reset;
    logic         v2, v4;
    logic [141:0] bus2;
    logic [283:0] bus4;
    logic         al2, al4;
    logic [75:0]  rf2;
    logic [151:0] rf4;
    logic [31:0]  pc2, pc4, wd2, wd4;
    logic [3:0]   wen2, wen4;
    logic [4:0]   wn2, wn4;

    int checks = 0;
    int errors = 0;

    wb_stage_mw #(.LANES(2)) dut2 (
        .clk(clk), .reset(reset), .ms_to_ws_valid(v2), .ms_to_ws_bus(bus2),
        .ws_allowin(al2), .ws_to_rf_bus(rf2), .debug_wb_pc(pc2),
        .debug_wb_rf_wen(wen2), .debug_wb_rf_wnum(wn2), .debug_wb_rf_wdata(wd2)
    );

    wb_stage_mw #(.LANES(4)) dut4 (
        .clk(clk), .reset(reset), .ms_to_ws_valid(v4), .ms_to_ws_bus(bus4),
        .ws_allowin(al4), .ws_to_rf_bus(rf4), .debug_wb_pc(pc4),
        .debug_wb_rf_wen(wen4), .debug_wb_rf_wnum(wn4), .debug_wb_rf_wdata(wd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [70:0] mk(input logic v, input logic we, input logic [4:0] d,
                                       input logic [31:0] r, input logic [31:0] p);
        return {v, we, d, r, p};
    endfunction

    function automatic logic [37:0] rfl(input logic we, input logic [4:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    function automatic logic [73:0] tr(input logic al, input logic [3:0] wen, input logic [4:0] wn,
                                       input logic [31:0] wd, input logic [31:0] pc);
        return {al, wen, wn, wd, pc};
    endfunction

    task automatic test_reset();
        logic [73:0] et;
        reset = 1'b1; v2 = 1'b0; v4 = 1'b0; bus2 = '0; bus4 = '0;
        repeat (2) @(negedge clk);
        et = tr(1'b1, 4'h0, 5'd0, 32'h0, 32'h0);
        checks++; if (rf2 !== 76'h0) begin errors++; $display("FAIL reset_rf2: got %h exp 0", rf2); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL reset_tr2: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        checks++; if (rf4 !== 152'h0) begin errors++; $display("FAIL reset_rf4: got %h exp 0", rf4); end
        checks++; if ({al4, wen4, wn4, wd4, pc4} !== et) begin errors++; $display("FAIL reset_tr4: got %h exp %h", {al4, wen4, wn4, wd4, pc4}, et); end
        reset = 1'b0;
    endtask

    task automatic test_pair();
        logic [75:0] er;
        logic [73:0] et;
        v2 = 1'b1;
        bus2 = {mk(1'b1, 1'b1, 5'd5, 32'h22, 32'h1c000004), mk(1'b1, 1'b1, 5'd4, 32'h11, 32'h1c000000)};
        @(negedge clk); v2 = 1'b0;
        er = {rfl(1'b1, 5'd5, 32'h22), rfl(1'b1, 5'd4, 32'h11)};
        et = tr(1'b0, 4'hF, 5'd4, 32'h11, 32'h1c000000);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL pair_rf_c1: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL pair_tr_c1: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        @(negedge clk);
        er = {rfl(1'b0, 5'd5, 32'h22), rfl(1'b0, 5'd4, 32'h11)};
        et = tr(1'b1, 4'hF, 5'd5, 32'h22, 32'h1c000004);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL pair_rf_c2: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL pair_tr_c2: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        @(negedge clk);
        et = tr(1'b1, 4'h0, 5'd5, 32'h22, 32'h1c000004);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL pair_rf_idle: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL pair_tr_idle: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
    endtask

    task automatic test_same_dest();
        logic [75:0] er;
        logic [73:0] et;
        v2 = 1'b1;
        bus2 = {mk(1'b1, 1'b1, 5'd6, 32'hBB, 32'h1c000014), mk(1'b1, 1'b1, 5'd6, 32'hAA, 32'h1c000010)};
        @(negedge clk); v2 = 1'b0;
        er = {rfl(1'b1, 5'd6, 32'hBB), rfl(1'b0, 5'd6, 32'hAA)};
        et = tr(1'b0, 4'hF, 5'd6, 32'hAA, 32'h1c000010);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL same_rf_c1: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL same_tr_c1: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        @(negedge clk);
        er = {rfl(1'b0, 5'd6, 32'hBB), rfl(1'b0, 5'd6, 32'hAA)};
        et = tr(1'b1, 4'hF, 5'd6, 32'hBB, 32'h1c000014);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL same_rf_c2: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL same_tr_c2: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        @(negedge clk);
    endtask

    task automatic test_lane0_invalid();
        logic [75:0] er;
        logic [73:0] et;
        v2 = 1'b1;
        bus2 = {mk(1'b1, 1'b1, 5'd7, 32'h5, 32'h1c000104), mk(1'b0, 1'b1, 5'd3, 32'h99, 32'h1c000100)};
        @(negedge clk); v2 = 1'b0;
        er = {rfl(1'b1, 5'd7, 32'h5), rfl(1'b0, 5'd3, 32'h99)};
        et = tr(1'b1, 4'hF, 5'd7, 32'h5, 32'h1c000104);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL inv0_rf_c1: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL inv0_tr_c1: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        @(negedge clk);
        er = {rfl(1'b0, 5'd7, 32'h5), rfl(1'b0, 5'd3, 32'h99)};
        et = tr(1'b1, 4'h0, 5'd7, 32'h5, 32'h1c000104);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL inv0_rf_c2: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL inv0_tr_c2: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
    endtask

    task automatic test_back_to_back();
        logic [75:0] er;
        logic [73:0] et;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                er = {rfl(1'b0, 5'd0, 32'h0), rfl(1'b1, 5'(k), 32'h100 + 32'(k - 1))};
                et = tr(1'b1, 4'hF, 5'(k), 32'h100 + 32'(k - 1), 32'h1c001000 + 32'(4 * (k - 1)));
                checks++; if (rf2 !== er) begin errors++; $display("FAIL b2b_rf[%0d]: got %h exp %h", k - 1, rf2, er); end
                checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL b2b_tr[%0d]: got %h exp %h", k - 1, {al2, wen2, wn2, wd2, pc2}, et); end
            end
            if (k < 10) begin
                v2 = 1'b1;
                bus2 = {mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0),
                        mk(1'b1, 1'b1, 5'(k + 1), 32'h100 + 32'(k), 32'h1c001000 + 32'(4 * k))};
            end else begin
                v2 = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_empty_then_pair();
        logic [75:0] er;
        logic [73:0] et;
        v2 = 1'b1;
        bus2 = {mk(1'b0, 1'b1, 5'd9, 32'h77, 32'h1c002004), mk(1'b0, 1'b1, 5'd8, 32'h66, 32'h1c002000)};
        @(negedge clk);
        er = {rfl(1'b0, 5'd9, 32'h77), rfl(1'b0, 5'd8, 32'h66)};
        et = tr(1'b1, 4'h0, 5'd10, 32'h109, 32'h1c001024);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL empty_rf: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL empty_tr: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        bus2 = {mk(1'b1, 1'b1, 5'd9, 32'h44, 32'h1c002104), mk(1'b1, 1'b1, 5'd8, 32'h33, 32'h1c002100)};
        @(negedge clk);
        er = {rfl(1'b1, 5'd9, 32'h44), rfl(1'b1, 5'd8, 32'h33)};
        et = tr(1'b0, 4'hF, 5'd8, 32'h33, 32'h1c002100);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL ep_rf_c1: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL ep_tr_c1: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        // Next group is offered while stalled and must be taken at the drain edge.
        bus2 = {mk(1'b0, 1'b0, 5'd0, 32'h0, 32'h0), mk(1'b1, 1'b1, 5'd10, 32'h55, 32'h1c002200)};
        @(negedge clk);
        er = {rfl(1'b0, 5'd9, 32'h44), rfl(1'b0, 5'd8, 32'h33)};
        et = tr(1'b1, 4'hF, 5'd9, 32'h44, 32'h1c002104);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL ep_rf_c2: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL ep_tr_c2: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        @(negedge clk); v2 = 1'b0;
        er = {rfl(1'b0, 5'd0, 32'h0), rfl(1'b1, 5'd10, 32'h55)};
        et = tr(1'b1, 4'hF, 5'd10, 32'h55, 32'h1c002200);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL ep_rf_next: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL ep_tr_next: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
        @(negedge clk);
        er = {rfl(1'b0, 5'd0, 32'h0), rfl(1'b0, 5'd10, 32'h55)};
        et = tr(1'b1, 4'h0, 5'd10, 32'h55, 32'h1c002200);
        checks++; if (rf2 !== er) begin errors++; $display("FAIL ep_rf_idle: got %h exp %h", rf2, er); end
        checks++; if ({al2, wen2, wn2, wd2, pc2} !== et) begin errors++; $display("FAIL ep_tr_idle: got %h exp %h", {al2, wen2, wn2, wd2, pc2}, et); end
    endtask

    task automatic test_reset_mid_drain();
        logic [151:0] er;
        logic [73:0]  et;
        v4 = 1'b1;
        bus4 = {mk(1'b1, 1'b1, 5'd4, 32'h40, 32'h1c00300c), mk(1'b1, 1'b1, 5'd3, 32'h30, 32'h1c003008),
                mk(1'b1, 1'b1, 5'd2, 32'h20, 32'h1c003004), mk(1'b1, 1'b1, 5'd1, 32'h10, 32'h1c003000)};
        @(negedge clk); v4 = 1'b0;
        er = {rfl(1'b1, 5'd4, 32'h40), rfl(1'b1, 5'd3, 32'h30), rfl(1'b1, 5'd2, 32'h20), rfl(1'b1, 5'd1, 32'h10)};
        et = tr(1'b0, 4'hF, 5'd1, 32'h10, 32'h1c003000);
        checks++; if (rf4 !== er) begin errors++; $display("FAIL quad_rf_c1: got %h exp %h", rf4, er); end
        checks++; if ({al4, wen4, wn4, wd4, pc4} !== et) begin errors++; $display("FAIL quad_tr_c1: got %h exp %h", {al4, wen4, wn4, wd4, pc4}, et); end
        @(negedge clk);
        et = tr(1'b0, 4'hF, 5'd2, 32'h20, 32'h1c003004);
        checks++; if ({al4, wen4, wn4, wd4, pc4} !== et) begin errors++; $display("FAIL quad_tr_c2: got %h exp %h", {al4, wen4, wn4, wd4, pc4}, et); end
        #2 reset = 1'b1;
        #1;
        et = tr(1'b1, 4'h0, 5'd0, 32'h0, 32'h0);
        checks++; if (rf4 !== 152'h0) begin errors++; $display("FAIL quad_rst_rf: got %h exp 0", rf4); end
        checks++; if ({al4, wen4, wn4, wd4, pc4} !== et) begin errors++; $display("FAIL quad_rst_tr: got %h exp %h", {al4, wen4, wn4, wd4, pc4}, et); end
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rf4 !== 152'h0) begin errors++; $display("FAIL quad_post_rf[%0d]: got %h exp 0", c, rf4); end
            checks++; if ({al4, wen4, wn4, wd4, pc4} !== et) begin errors++; $display("FAIL quad_post_tr[%0d]: got %h exp %h", c, {al4, wen4, wn4, wd4, pc4}, et); end
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_same_dest();
        test_lane0_invalid();
        test_back_to_back();
        test_empty_then_pair();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/wb_stage_mw.md
# wb_stage_mw

Multi-lane writeback stage: the parametrised successor to the single-issue writeback stage, sitting at the end of the pipeline after the memory stage. It accepts a group of up to LANES retiring instructions per handshake and issues all their register-file writes in one cycle. It also serialises the group onto the single-lane difftest trace port, one retired lane per cycle, stalling upstream until the group has drained.

## Interface
- LANES, 2, lanes per group (1..4)
- DATA_W, 32, result width
- REG_AW, 5, register index width
- PC_W, 32, PC width
- Derived: LANE_W = 2+REG_AW+DATA_W+PC_W (71 at defaults); RF_W = 1+REG_AW+DATA_W

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ms_to_ws_valid  in  1  group valid from memory stage
- ms_to_ws_bus  in  LANES*LANE_W  lane i at [i*LANE_W +: LANE_W]; fields MSB→LSB: lane_v, gr_we, dest, result, pc
- ws_allowin  out  1  stage can accept a group this cycle
- ws_to_rf_bus  out  LANES*RF_W  lane i: {we, waddr, wdata}; also serves as the forwarding source to decode
- debug_wb_pc  out  PC_W  traced lane PC
- debug_wb_rf_wen  out  4  {4{traced lane gr_we}}; 0 when no lane is traced
- debug_wb_rf_wnum  out  REG_AW  traced lane dest
- debug_wb_rf_wdata  out  DATA_W  traced lane result

## Operation
- Registers: ws_valid, bus_r (LANES*LANE_W), pend mask (LANES bits), rf_fire flag. All are asynchronously cleared by reset.
- Accept = ms_to_ws_valid && ws_allowin. On accept:
  - bus_r is loaded.
  - pend is set to the lane_v bits.
  - rf_fire is set to 1.
  - ws_valid is set to 1.
- If ws_allowin && !ms_to_ws_valid, ws_valid is cleared to 0.
- RF write: lane i we = ws_valid && rf_fire && lane_v[i] && gr_we[i] && !kill[i].
  - kill[i] = a higher-index lane j>i has lane_v, gr_we and the same dest. The later lane wins.
  - rf_fire clears after the first valid cycle, so each group writes exactly once.
  - Writes to dest 0 are passed through; the register file ignores them.
- Trace: each valid cycle, pick the lowest set bit k of pend and drive lane k's fields onto the debug_* ports.
  - pend[k] clears at the clock edge.
  - Killed lanes are still traced with their own data, so the trace matches the golden reference.
- ws_ready_go = popcount(pend) ≤ 1.
- ws_allowin = !ws_valid || ws_ready_go.
- Empty group (valid with all lane_v=0): ready_go is 1 immediately, no RF write, debug_wb_rf_wen=0.
- Idle (ws_valid=0): all we=0, debug_wb_rf_wen=0; debug_wb_pc/wnum/wdata hold the last values.

## Timing
- Reset values: ws_allowin=1, all ws_to_rf_bus fields 0, debug_wb_rf_wen=0, debug_wb_pc/wnum/wdata=0.
- Group of n valid lanes accepted at edge T:
  - Cycle T+1: all RF writes, trace of the first lane.
  - Cycles T+1..T+n: trace lanes in ascending index, one per cycle.
  - ws_allowin is 0 during T+1..T+n−1 and 1 in cycle T+n.
  - The next group can be accepted at the end of cycle T+n with no bubble.
- n≤1: fully pipelined, one group per cycle, matching single-issue throughput.
- Reset asserted mid-drain: pend, ws_valid and rf_fire clear immediately. Remaining lanes are dropped and no further writes occur.
- Simultaneous last-trace and accept: the new bus_r and pend load at the same edge the old pend bit would clear. The new group wins and there is no overlap.

## Structure
- myCPU.h gains macros WS_LANES, WS_LANE_W and WS_RF_W, plus field-offset macros for lane_v, gr_we, dest, result and pc. Memory stage and decode use these macros for packing and forwarding.
- One sub-module, wb_trace_ser, contains:
  - the pend register and the lowest-set-bit picker;
  - the popcount-≤1 ready logic;
  - the trace mux.
- The top level keeps the handshake, bus register, RF write and kill logic.

## Test plan
- LANES=2, group {lane0: pc 0x1c000000, r4←0x11; lane1: pc 0x1c000004, r5←0x22} → one cycle with both RF writes; trace shows r4/0x11, then r5/0x22; ws_allowin=0 for exactly 1 cycle.
- Same dest: lane0 r6←0xAA, lane1 r6←0xBB → only the lane1 write is enabled; trace reports both, 0xAA first.
- Lane0 lane_v=0, lane1 r7←0x5 → single trace cycle of lane1; no stall; lane0 we=0.
- Stream of ten single-lane groups back to back → one retire per cycle; ws_allowin stays 1; PCs traced in order.
- Empty group followed by a 2-lane group → no write and wen=0 for the empty group, then normal 2-cycle drain.
- Reset pulse during the second trace cycle of a 4-lane group (LANES=4) → all outputs return to reset values without waiting for the clock; no further writes; ws_allowin=1.
